// File: rtl/cal_fwft_averager.sv
// ---------------------------------------------------------------------------
// cal_fwft_averager
//
// Sits directly behind the calibrator's first-word-fall-through averaging
// FIFO. Words are popped from the show-ahead port, 2**LOG2_NAVG consecutive
// words are summed, and their rounded mean is presented on a valid/ready
// output that feeds the calibration datapath.
//
// Parameters
//   DWIDTH     width of fifo_dout and avg_dout
//   LOG2_NAVG  log2 of samples per average (0..8, 0 = passthrough)
//   SIGNED     1: two's-complement data, 0: unsigned data
//   ROUND      1: round half up before the shift, 0: truncate toward -inf
//
// Ports
//   clk         single clock, rising edge
//   aresetn     asynchronous active-low reset
//   clear       synchronous clear of partial sum, count and output
//   enable      1 = pops allowed, 0 = hold (partial sum retained)
//   fifo_empty  FIFO empty; fifo_dout is valid when 0
//   fifo_dout   FIFO head word
//   fifo_rd_en  pop strobe (combinational)
//   avg_dout    averaged result
//   avg_valid   avg_dout valid
//   avg_ready   downstream accepts avg_dout
//   avg_count   number of averages accepted downstream (wraps)
//   busy        a partial sum is in progress
//
// Output handshake: a result transfers on every rising edge where
// avg_valid & avg_ready are both 1. Once avg_valid is raised it stays high
// and avg_dout stays stable until that transfer; avg_valid never depends
// combinationally on avg_ready.
// ---------------------------------------------------------------------------
module cal_fwft_averager #(
    parameter int DWIDTH    = 32,
    parameter int LOG2_NAVG = 4,
    parameter bit SIGNED    = 1'b1,
    parameter bit ROUND     = 1'b1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              clear,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] avg_dout,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [15:0]       avg_count,
    output logic              busy
);

    // The extra LOG2_NAVG bits hold the sum of 2**LOG2_NAVG full-scale words
    // plus the rounding constant without overflow.
    localparam int AW     = DWIDTH + LOG2_NAVG;
    localparam int CW     = (LOG2_NAVG > 0) ? LOG2_NAVG : 1;
    localparam int RND_SH = (LOG2_NAVG > 0) ? LOG2_NAVG - 1 : 0;

    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_NAVG) - 1);
    localparam logic [AW-1:0] RND      = (ROUND && (LOG2_NAVG > 0))
                                         ? (AW'(1) << RND_SH) : '0;

    typedef enum logic {
        S_ACC = 1'b0,   // accumulating, no result pending
        S_OUT = 1'b1    // result pending on the output
    } state_t;

    state_t            state;
    logic [AW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     din_ext;
    logic [AW-1:0]     sum_fin;
    logic              pop;
    logic              last;
    logic              accept;

    always_comb begin
        din_ext = AW'(fifo_dout);
        if (SIGNED) begin
            din_ext = AW'($signed(fifo_dout));
        end
    end

    // A pop is blocked only while a result is pending and not being taken,
    // so the stream keeps flowing at one word per clock when avg_ready = 1.
    // aresetn gates the strobe so nothing is popped while reset is held.
    assign pop        = aresetn & enable & ~clear & ~fifo_empty
                        & ~(avg_valid & ~avg_ready);
    assign fifo_rd_en = pop;

    assign accept  = avg_valid & avg_ready;
    // With LOG2_NAVG = 0 the count never leaves 0, so every pop is the last.
    assign last    = (cnt == CNT_LAST);
    assign sum_fin = acc + din_ext + RND;

    assign avg_valid = (state == S_OUT);
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            avg_dout  <= '0;
            avg_count <= '0;
        end else if (clear) begin
            state     <= S_ACC;
            acc       <= '0;
            cnt       <= '0;
            avg_dout  <= '0;
            avg_count <= '0;
        end else begin
            if (accept) begin
                avg_count <= avg_count + 16'd1;
                state     <= S_ACC;
            end
            if (pop) begin
                if (last) begin
                    // Taking the low DWIDTH bits after the shift is both the
                    // arithmetic and the logical shift: the mean always fits.
                    avg_dout <= DWIDTH'(sum_fin >> LOG2_NAVG);
                    acc      <= '0;
                    cnt      <= '0;
                    // A completion on the same edge as an accept overrides
                    // the drop to S_ACC above, keeping avg_valid high.
                    state    <= S_OUT;
                end else begin
                    acc <= acc + din_ext;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cal_fwft_averager.sv
// ---------------------------------------------------------------------------
// tb_cal_fwft_averager
//
// Bench for cal_fwft_averager. The main instance uses LOG2_NAVG = 4 with
// signed, rounded data; a second instance uses LOG2_NAVG = 0 for the
// passthrough case. A software FWFT FIFO feeds the main instance, and a
// reference model built from the popped words (plain integer mean with
// round-half-up) predicts every result the instance must emit.
// ---------------------------------------------------------------------------
module tb_cal_fwft_averager;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int N  = 1 << L;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          aresetn;

    // main instance
    logic          clear;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [DW-1:0] avg_dout;
    logic          avg_valid;
    logic          avg_ready;
    logic [15:0]   avg_count;
    logic          busy;

    // passthrough instance
    logic          z_clear;
    logic          z_enable;
    logic          z_empty;
    logic [DW-1:0] z_dout;
    logic          z_rd_en;
    logic [DW-1:0] z_avg_dout;
    logic          z_avg_valid;
    logic          z_avg_ready;
    logic [15:0]   z_avg_count;
    logic          z_busy;

    cal_fwft_averager #(.DWIDTH(DW), .LOG2_NAVG(L), .SIGNED(1'b1), .ROUND(1'b1)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear      (clear),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .avg_dout   (avg_dout),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .avg_count  (avg_count),
        .busy       (busy)
    );

    cal_fwft_averager #(.DWIDTH(DW), .LOG2_NAVG(0), .SIGNED(1'b1), .ROUND(1'b1)) dut0 (
        .clk        (clk),
        .aresetn    (aresetn),
        .clear      (z_clear),
        .enable     (z_enable),
        .fifo_empty (z_empty),
        .fifo_dout  (z_dout),
        .fifo_rd_en (z_rd_en),
        .avg_dout   (z_avg_dout),
        .avg_valid  (z_avg_valid),
        .avg_ready  (z_avg_ready),
        .avg_count  (z_avg_count),
        .busy       (z_busy)
    );

    // ---------------- bench state ----------------
    int            vectors;
    int            miscompares;

    logic [DW-1:0] stim [0:1023];   // software FIFO storage
    int            wr_idx;
    int            rd_idx;
    bit            pop_flag;        // pop seen at the last falling edge
    bit            gap_en;          // random empty gaps
    bit            ready_rand;      // random avg_ready

    longint        part_q[$];       // words of the average in progress
    logic [DW-1:0] exp_q[$];        // expected results in order
    int            model_count;
    logic [DW-1:0] last_out;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        stim[wr_idx] = w;
        wr_idx++;
    endtask

    // Reference model and scoreboard, evaluated at the falling edge with the
    // values that the next rising edge will act on.
    task automatic sample();
        logic [DW-1:0] e;
        longint        s;
        if (!aresetn || clear) begin
            part_q.delete();
            exp_q.delete();
            model_count = 0;
        end else begin
            if (avg_valid && avg_ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL avg_unexpected got=%0h exp=none", avg_dout);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("avg_dout", 64'(avg_dout), 64'(e));
                end
                last_out    = avg_dout;
                model_count = (model_count + 1) % 65536;
            end
            if (fifo_rd_en) begin
                part_q.push_back(longint'($signed(fifo_dout)));
                if (part_q.size() == N) begin
                    s = N / 2;
                    foreach (part_q[i]) s += part_q[i];
                    exp_q.push_back(DW'(s >>> L));
                    part_q.delete();
                end
            end
        end
        pop_flag = fifo_rd_en;
    endtask

    // Advance the software FIFO just after the rising edge.
    task automatic fifo_update();
        if (pop_flag && rd_idx < wr_idx) rd_idx++;
        if (ready_rand) avg_ready = 1'($urandom_range(0, 1));
        if (rd_idx == wr_idx || (gap_en && $urandom_range(0, 2) == 0)) begin
            fifo_empty = 1'b1;
            fifo_dout  = $urandom;
        end else begin
            fifo_empty = 1'b0;
            fifo_dout  = stim[rd_idx];
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        fifo_update();
    endtask

    task automatic wait_popped(input string tag);
        int n;
        n = 0;
        while (rd_idx != wr_idx && n < 300) begin
            step();
            n++;
        end
        vectors++;
        assert (rd_idx == wr_idx) else begin
            miscompares++;
            $error("FAIL %s_timeout got=%0d exp=%0d", tag, rd_idx, wr_idx);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (!(rd_idx == wr_idx && exp_q.size() == 0 && !avg_valid) && n < 600) begin
            step();
            n++;
        end
        vectors++;
        assert (rd_idx == wr_idx && exp_q.size() == 0 && !avg_valid) else begin
            miscompares++;
            $error("FAIL %s_timeout got=%0d exp=0", tag, exp_q.size());
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        check({tag, "_dout"},  64'(avg_dout),   64'd0);
        check({tag, "_valid"}, 64'(avg_valid),  64'd0);
        check({tag, "_count"}, 64'(avg_count),  64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] held;
        logic          b;
        logic [DW-1:0] zw [0:99];

        vectors = 0; miscompares = 0;
        wr_idx = 0; rd_idx = 0; pop_flag = 0;
        gap_en = 0; ready_rand = 0;
        model_count = 0; last_out = '0;
        aresetn = 1'b0; clear = 1'b0; enable = 1'b1;
        fifo_empty = 1'b1; fifo_dout = '0; avg_ready = 1'b1;
        z_clear = 1'b0; z_enable = 1'b0; z_empty = 1'b1; z_dout = '0; z_avg_ready = 1'b1;

        #1;
        check_zero("reset");
        check("reset_z_count", 64'(z_avg_count), 64'd0);
        step();
        step();
        aresetn = 1'b1;
        step();

        // 1: ramp 1..16 -> (136 + 8) >> 4 = 9
        for (int k = 1; k <= 16; k++) push(DW'(k));
        wait_drain("ramp");
        check("ramp_value", 64'(last_out), 64'd9);
        check("ramp_count", 64'(avg_count), 64'd1);
        check("ramp_busy",  64'(busy), 64'd0);

        // 2: full-scale and alternating
        for (int k = 0; k < 16; k++) push(32'h7FFF_FFFF);
        wait_drain("fs_pos");
        check("fs_pos_value", 64'(last_out), 64'h7FFF_FFFF);
        for (int k = 0; k < 16; k++) push(32'h8000_0000);
        wait_drain("fs_neg");
        check("fs_neg_value", 64'(last_out), 64'h8000_0000);
        for (int k = 0; k < 16; k++) push((k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0);
        wait_drain("alt");
        check("alt_value", 64'(last_out), 64'd0);
        check("alt_count", 64'(avg_count), 64'(model_count));

        // 3: back-pressure while a result is pending
        avg_ready = 1'b0;
        for (int k = 0; k < 32; k++) push($urandom);
        begin
            int n;
            n = 0;
            while (!avg_valid && n < 100) begin
                step();
                n++;
            end
        end
        check("bp_valid_seen", 64'(avg_valid), 64'd1);
        held = avg_dout;
        check("bp_held_value", 64'(held), 64'(exp_q.size() != 0 ? exp_q[0] : ~held));
        repeat (5) begin
            step();
            check("bp_rd_en",  64'(fifo_rd_en), 64'd0);
            check("bp_valid",  64'(avg_valid),  64'd1);
            check("bp_stable", 64'(avg_dout),   64'(held));
        end
        avg_ready = 1'b1;
        wait_drain("bp");
        check("bp_count", 64'(avg_count), 64'(model_count));

        // 4: random empty gaps and an enable pause mid-average
        gap_en = 1;
        for (int k = 0; k < 32; k++) push($urandom);
        repeat (6) step();
        enable = 1'b0;
        b = busy;
        repeat (10) begin
            step();
            check("en_off_rd_en", 64'(fifo_rd_en), 64'd0);
            check("en_off_busy",  64'(busy),       64'(b));
        end
        enable = 1'b1;
        wait_drain("gaps");
        gap_en = 0;
        check("gaps_count", 64'(avg_count), 64'(model_count));

        // 5a: asynchronous reset after 7 pops
        for (int k = 0; k < 7; k++) push($urandom);
        wait_popped("pre_rst");
        step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        check_zero("mid_rst");
        step();
        step();
        aresetn = 1'b1;
        for (int k = 0; k < 16; k++) push($urandom);
        wait_drain("post_rst");
        check("post_rst_count", 64'(avg_count), 64'd1);

        // 5b: same sequence with clear
        for (int k = 0; k < 7; k++) push($urandom);
        wait_popped("pre_clr");
        step();
        check("pre_clr_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        for (int k = 0; k < 16; k++) push($urandom);
        step();
        check("clr_fifo_has_data", 64'(fifo_empty), 64'd0);
        check_zero("clr");
        step();
        check("clr_hold_rd_en", 64'(fifo_rd_en), 64'd0);
        clear = 1'b0;
        wait_drain("post_clr");
        check("post_clr_count", 64'(avg_count), 64'd1);

        // random avg_ready against a random stream
        ready_rand = 1;
        gap_en = 1;
        for (int k = 0; k < 64; k++) push($urandom);
        wait_popped("rand_rdy");
        ready_rand = 0;
        gap_en = 0;
        avg_ready = 1'b1;
        wait_drain("rand_rdy");
        check("rand_rdy_count", 64'(avg_count), 64'(model_count));

        // 6: passthrough instance, 100 words back to back
        for (int i = 0; i < 100; i++) zw[i] = $urandom;
        z_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            z_dout  = zw[i];
            z_empty = 1'b0;
            @(negedge clk);
            check("z_rd_en", 64'(z_rd_en), 64'd1);
            if (i > 0) begin
                check("z_valid", 64'(z_avg_valid), 64'd1);
                check("z_dout",  64'(z_avg_dout),  64'(zw[i-1]));
            end
            @(posedge clk);
            #1;
        end
        z_empty = 1'b1;
        z_dout  = $urandom;
        @(negedge clk);
        check("z_last_valid", 64'(z_avg_valid), 64'd1);
        check("z_last_dout",  64'(z_avg_dout),  64'(zw[99]));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("z_count",     64'(z_avg_count), 64'd100);
        check("z_idle",      64'(z_avg_valid), 64'd0);
        check("z_busy",      64'(z_busy),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
